// File: rtl/spi_ip_xfer_ctrl_if.sv
// spi_ip_xfer_ctrl_if
//   Bundles the transfer controller's register-side request, shift-register
//   strobes and divider hand-off signals.
//   Modports:
//     slave  - the controller (spi_ip_xfer_ctrl)
//     master - the environment driving it (register block / divider / bench)
//   Optional macro SPI_IP_XFER_CTRL_ABORT_EN adds xfc_abort_i / xfc_aborted_o.
interface spi_ip_xfer_ctrl_if #(
   parameter int PARAM_MAX_DIV   = 8,
   parameter int PARAM_LEN_WIDTH = 5
);
   localparam int DIV_W = (PARAM_MAX_DIV > 1) ? $clog2(PARAM_MAX_DIV) : 1;

   logic                       xfc_start_i;
   logic [PARAM_LEN_WIDTH-1:0] xfc_len_i;
   logic [DIV_W-1:0]           xfc_div_i;
   logic                       xfc_cpha_i;
   logic                       xfc_busy_o;
   logic                       xfc_done_o;
   logic                       xfc_cs_n_o;
   logic                       xfc_sck_en_o;
   logic                       xfc_shift_o;
   logic                       xfc_sample_o;
   logic                       clkd_enable_o;
   logic [DIV_W-1:0]           clkd_clk_div_o;
   logic                       clkd_time_base_i;
`ifdef SPI_IP_XFER_CTRL_ABORT_EN
   logic                       xfc_abort_i;
   logic                       xfc_aborted_o;

   modport slave (
      input  xfc_start_i, xfc_len_i, xfc_div_i, xfc_cpha_i, clkd_time_base_i, xfc_abort_i,
      output xfc_busy_o, xfc_done_o, xfc_cs_n_o, xfc_sck_en_o, xfc_shift_o, xfc_sample_o,
             clkd_enable_o, clkd_clk_div_o, xfc_aborted_o
   );
   modport master (
      output xfc_start_i, xfc_len_i, xfc_div_i, xfc_cpha_i, clkd_time_base_i, xfc_abort_i,
      input  xfc_busy_o, xfc_done_o, xfc_cs_n_o, xfc_sck_en_o, xfc_shift_o, xfc_sample_o,
             clkd_enable_o, clkd_clk_div_o, xfc_aborted_o
   );
`else
   modport slave (
      input  xfc_start_i, xfc_len_i, xfc_div_i, xfc_cpha_i, clkd_time_base_i,
      output xfc_busy_o, xfc_done_o, xfc_cs_n_o, xfc_sck_en_o, xfc_shift_o, xfc_sample_o,
             clkd_enable_o, clkd_clk_div_o
   );
   modport master (
      output xfc_start_i, xfc_len_i, xfc_div_i, xfc_cpha_i, clkd_time_base_i,
      input  xfc_busy_o, xfc_done_o, xfc_cs_n_o, xfc_sck_en_o, xfc_shift_o, xfc_sample_o,
             clkd_enable_o, clkd_clk_div_o
   );
`endif
endinterface

// File: rtl/spi_ip_xfer_ctrl.sv
// spi_ip_xfer_ctrl
//   SPI transfer sequencer in front of the spi_ip_clk_div divider. Loads the
//   divider select while the divider is disabled, enables it, frames CS with
//   PARAM_CS_SETUP SCK periods of lead/trail, and counts divider time-base
//   pulses to issue one-cycle shift/sample strobes for len+1 bits.
//   Ports:
//     xfc_clk_i    system clock (shared with the divider)
//     xfc_rst_n_i  asynchronous active-low reset
//     bus          spi_ip_xfer_ctrl_if.slave: start/len/div/cpha request,
//                  busy/done/cs_n/sck_en/shift/sample status and strobes,
//                  clkd_enable_o/clkd_clk_div_o/clkd_time_base_i divider link
//   Optional macro SPI_IP_XFER_CTRL_ABORT_EN: xfc_abort_i forces the active
//   transfer to DONE on the next cycle and flags it on xfc_aborted_o.
module spi_ip_xfer_ctrl #(
   parameter int PARAM_MAX_DIV   = 8,
   parameter int PARAM_LEN_WIDTH = 5,
   parameter int PARAM_CS_SETUP  = 1
) (
   input logic               xfc_clk_i,
   input logic               xfc_rst_n_i,
   spi_ip_xfer_ctrl_if.slave bus
);
   localparam int DIV_W  = (PARAM_MAX_DIV > 1) ? $clog2(PARAM_MAX_DIV) : 1;
   // Counter must reach 2*2^LEN_WIDTH and 2*CS_SETUP without wrapping.
   localparam int CW_LEN = PARAM_LEN_WIDTH + 2;
   localparam int CW_CS  = $clog2(2 * PARAM_CS_SETUP + 1);
   localparam int CW     = (CW_LEN > CW_CS) ? CW_LEN : CW_CS;
   localparam logic [CW-1:0] FRAME_LAST = CW'(2 * PARAM_CS_SETUP - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEAD  = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_TRAIL = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]                 state;
   logic [CW-1:0]              cnt;
   logic [PARAM_LEN_WIDTH-1:0] len_q;
   logic                       cpha_q;
   logic [DIV_W-1:0]           div_q;
   logic                       en_q;
   logic                       shift_q;
   logic                       sample_q;

   logic [CW-1:0] p;          // 1-based index of the current XFER pulse
   logic [CW-1:0] xfer_last;  // 2*(len+1)
   logic          p_odd;
   logic          p_final;
   logic          active;
   logic          abort_req;

   assign p         = cnt + CW'(1);
   assign xfer_last = (CW'(len_q) + CW'(1)) << 1;
   assign p_odd     = p[0];
   assign p_final   = (p == xfer_last);
   assign active    = (state == S_LEAD) || (state == S_XFER) || (state == S_TRAIL);

`ifdef SPI_IP_XFER_CTRL_ABORT_EN
   logic aborted_q;
   assign abort_req         = bus.xfc_abort_i & active;
   assign bus.xfc_aborted_o = aborted_q;

   always_ff @(posedge xfc_clk_i or negedge xfc_rst_n_i) begin
      if (!xfc_rst_n_i) aborted_q <= 1'b0;
      else              aborted_q <= abort_req;
   end
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge xfc_clk_i or negedge xfc_rst_n_i) begin
      if (!xfc_rst_n_i) begin
         state    <= S_IDLE;
         cnt      <= '0;
         len_q    <= '0;
         cpha_q   <= 1'b0;
         div_q    <= '0;
         en_q     <= 1'b0;
         shift_q  <= 1'b0;
         sample_q <= 1'b0;
      end else begin
         shift_q  <= 1'b0;
         sample_q <= 1'b0;
         if (abort_req) begin
            state <= S_DONE;
            en_q  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  en_q <= 1'b0;
                  cnt  <= '0;
                  // Select is loaded here while en_q is still low; en_q only
                  // rises one cycle later from LEAD.
                  if (bus.xfc_start_i) begin
                     len_q  <= bus.xfc_len_i;
                     cpha_q <= bus.xfc_cpha_i;
                     div_q  <= bus.xfc_div_i;
                     state  <= S_LEAD;
                  end
               end
               S_LEAD: begin
                  en_q <= 1'b1;
                  if (bus.clkd_time_base_i) begin
                     if (cnt == FRAME_LAST) begin
                        cnt   <= '0;
                        state <= S_XFER;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
               end
               S_XFER: begin
                  if (bus.clkd_time_base_i) begin
                     if (cpha_q) begin
                        shift_q  <= p_odd;
                        sample_q <= !p_odd;
                     end else begin
                        sample_q <= p_odd;
                        shift_q  <= !p_odd && !p_final;
                     end
                     if (p_final) begin
                        cnt   <= '0;
                        state <= S_TRAIL;
                     end else begin
                        cnt <= p;
                     end
                  end
               end
               S_TRAIL: begin
                  if (bus.clkd_time_base_i) begin
                     if (cnt == FRAME_LAST) begin
                        cnt   <= '0;
                        en_q  <= 1'b0;
                        state <= S_DONE;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
               end
               S_DONE: begin
                  en_q  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  en_q  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.xfc_busy_o     = active;
   assign bus.xfc_done_o     = (state == S_DONE);
   assign bus.xfc_cs_n_o     = !active;
   assign bus.xfc_sck_en_o   = (state == S_XFER);
   assign bus.xfc_shift_o    = shift_q;
   assign bus.xfc_sample_o   = sample_q;
   assign bus.clkd_enable_o  = en_q;
   assign bus.clkd_clk_div_o = div_q;
endmodule

// File: tb/tb_spi_ip_xfer_ctrl.sv
// tb_spi_ip_xfer_ctrl
//   Self-checking bench for spi_ip_xfer_ctrl. A small divider model produces
//   time-base pulses every div+2 cycles while enabled; a monitor records
//   strobe order, pulse counts and done pulses, and each scenario compares
//   them with a bit-level model of the SPI framing rules.
`timescale 1ns/1ps
module tb_spi_ip_xfer_ctrl;
   localparam int MAX_DIV  = 8;
   localparam int LEN_W    = 5;
   localparam int CS_SETUP = 1;
   localparam int DIV_W    = 3;
   localparam int BOUND    = 5000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_ip_xfer_ctrl_if #(.PARAM_MAX_DIV(MAX_DIV), .PARAM_LEN_WIDTH(LEN_W)) bus ();

   spi_ip_xfer_ctrl #(
      .PARAM_MAX_DIV(MAX_DIV), .PARAM_LEN_WIDTH(LEN_W), .PARAM_CS_SETUP(CS_SETUP)
   ) dut (
      .xfc_clk_i(clk),
      .xfc_rst_n_i(rst_n),
      .bus(bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // divider model: one time-base pulse every div+2 cycles while enabled
   logic [3:0] dcnt;
   logic       tb_pulse;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt <= '0; tb_pulse <= 1'b0;
      end else if (!bus.clkd_enable_o) begin
         dcnt <= '0; tb_pulse <= 1'b0;
      end else if (dcnt == 4'(bus.clkd_clk_div_o) + 4'd1) begin
         dcnt <= '0; tb_pulse <= 1'b1;
      end else begin
         dcnt <= dcnt + 4'd1; tb_pulse <= 1'b0;
      end
   end
   assign bus.clkd_time_base_i = tb_pulse;

   // monitor
   bit               mon_clr = 1'b0;
   int               n_xfer_tb, n_frame_tb, n_done, n_div_chg;
   string            ev;
   logic [DIV_W-1:0] div_at_en, prev_div;
   logic             prev_en;
   always @(negedge clk) begin
      if (mon_clr) begin
         n_xfer_tb <= 0; n_frame_tb <= 0; n_done <= 0; n_div_chg <= 0;
         ev <= ""; div_at_en <= '0;
      end else begin
         if (bus.clkd_time_base_i && bus.xfc_sck_en_o) n_xfer_tb <= n_xfer_tb + 1;
         if (bus.clkd_time_base_i && !bus.xfc_cs_n_o && !bus.xfc_sck_en_o) n_frame_tb <= n_frame_tb + 1;
         if (bus.xfc_done_o) n_done <= n_done + 1;
         if (bus.xfc_shift_o && bus.xfc_sample_o) ev <= {ev, "X"};
         else if (bus.xfc_shift_o)                ev <= {ev, "s"};
         else if (bus.xfc_sample_o)               ev <= {ev, "a"};
         if (bus.clkd_enable_o && prev_en && bus.clkd_clk_div_o != prev_div) n_div_chg <= n_div_chg + 1;
         if (bus.clkd_enable_o && !prev_en) div_at_en <= bus.clkd_clk_div_o;
      end
      prev_en  <= bus.clkd_enable_o;
      prev_div <= bus.clkd_clk_div_o;
   end

   // reference: per bit, cpha=0 samples then shifts (no shift after the last
   // bit); cpha=1 shifts then samples
   function automatic string exp_seq(input int l, input bit c);
      string s;
      s = "";
      for (int b = 0; b <= l; b++) begin
         if (c) s = {s, "sa"};
         else begin
            s = {s, "a"};
            if (b != l) s = {s, "s"};
         end
      end
      return s;
   endfunction

   task automatic mon_reset();
      mon_clr = 1'b1;
      repeat (2) @(posedge clk);
      mon_clr = 1'b0;
   endtask

   // returns at the negedge of the first LEAD cycle; request inputs are
   // scrambled afterwards, which must not affect the transfer
   task automatic do_start(input int d, input int l, input bit c);
      @(negedge clk);
      bus.xfc_div_i = DIV_W'(d); bus.xfc_len_i = LEN_W'(l); bus.xfc_cpha_i = c;
      bus.xfc_start_i = 1'b1;
      @(negedge clk);
      bus.xfc_start_i = 1'b0;
      bus.xfc_div_i = DIV_W'($urandom); bus.xfc_len_i = LEN_W'($urandom);
      bus.xfc_cpha_i = 1'($urandom);
   endtask

   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int i = 0; i < BOUND; i++) begin
         if (bus.xfc_done_o) begin to = 1'b0; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.xfc_start_i = 1'b0; bus.xfc_len_i = '0; bus.xfc_div_i = '0; bus.xfc_cpha_i = 1'b0;
`ifdef SPI_IP_XFER_CTRL_ABORT_EN
      bus.xfc_abort_i = 1'b0;
`endif
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.xfc_busy_o, bus.xfc_done_o, bus.xfc_cs_n_o, bus.xfc_sck_en_o, bus.xfc_shift_o,
           bus.xfc_sample_o, bus.clkd_enable_o} !== 7'b0010000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0010000", {bus.xfc_busy_o, bus.xfc_done_o,
                  bus.xfc_cs_n_o, bus.xfc_sck_en_o, bus.xfc_shift_o, bus.xfc_sample_o, bus.clkd_enable_o});
      end
      n_checks++;
      if (bus.clkd_clk_div_o !== '0) begin
         n_fail++; $display("FAIL reset_div: got %0d want 0", bus.clkd_clk_div_o);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.xfc_busy_o !== 1'b0 || bus.xfc_cs_n_o !== 1'b1 || bus.clkd_enable_o !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: busy=%b cs_n=%b en=%b want 0 1 0",
                            bus.xfc_busy_o, bus.xfc_cs_n_o, bus.clkd_enable_o);
      end
   endtask

   task automatic test_transfer(input string nm, input int d, input int l, input bit c);
      bit    to;
      string ex;
      ex = exp_seq(l, c);
      mon_reset();
      do_start(d, l, c);
      n_checks++;
      if (bus.xfc_cs_n_o !== 1'b0 || bus.xfc_busy_o !== 1'b1) begin
         n_fail++; $display("FAIL %s lead_cs: cs_n=%b busy=%b want 0 1", nm, bus.xfc_cs_n_o, bus.xfc_busy_o);
      end
      n_checks++;
      if (bus.clkd_clk_div_o !== DIV_W'(d) || bus.clkd_enable_o !== 1'b0) begin
         n_fail++; $display("FAIL %s div_load: div=%0d en=%b want %0d 0", nm, bus.clkd_clk_div_o,
                            bus.clkd_enable_o, d);
      end
      @(negedge clk);
      n_checks++;
      if (bus.clkd_enable_o !== 1'b1) begin
         n_fail++; $display("FAIL %s enable_rise: got %b want 1", nm, bus.clkd_enable_o);
      end
      wait_done(to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL %s timeout: no done within %0d cycles", nm, BOUND); end
      n_checks++;
      if (n_done != 1) begin n_fail++; $display("FAIL %s done_count: got %0d want 1", nm, n_done); end
      n_checks++;
      if (n_xfer_tb != 2 * (l + 1)) begin
         n_fail++; $display("FAIL %s xfer_pulses: got %0d want %0d", nm, n_xfer_tb, 2 * (l + 1));
      end
      n_checks++;
      if (n_frame_tb != 4 * CS_SETUP) begin
         n_fail++; $display("FAIL %s frame_pulses: got %0d want %0d", nm, n_frame_tb, 4 * CS_SETUP);
      end
      n_checks++;
      if (ev != ex) begin n_fail++; $display("FAIL %s strobes: got %s want %s", nm, ev, ex); end
      n_checks++;
      if (div_at_en !== DIV_W'(d) || n_div_chg != 0) begin
         n_fail++; $display("FAIL %s div_stable: at_en=%0d changes=%0d want %0d 0", nm, div_at_en, n_div_chg, d);
      end
      n_checks++;
      if (bus.xfc_busy_o !== 1'b0 || bus.xfc_cs_n_o !== 1'b1) begin
         n_fail++; $display("FAIL %s end_idle: busy=%b cs_n=%b want 0 1", nm, bus.xfc_busy_o, bus.xfc_cs_n_o);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      mon_reset();
      do_start(2, 7, 0);
      to = 1'b1;
      for (int i = 0; i < BOUND; i++) begin
         if (bus.xfc_sck_en_o) begin to = 1'b0; break; end
         @(negedge clk);
      end
      bus.xfc_div_i = 3'd5; bus.xfc_start_i = 1'b1;
      @(negedge clk);
      bus.xfc_start_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (to || bus.clkd_clk_div_o !== 3'd2 || bus.xfc_busy_o !== 1'b1) begin
         n_fail++; $display("FAIL b2b_busy_start: div=%0d busy=%b to=%b want 2 1 0",
                            bus.clkd_clk_div_o, bus.xfc_busy_o, to);
      end
      to = 1'b1;
      for (int i = 0; i < BOUND; i++) begin
         if (bus.xfc_done_o) begin to = 1'b0; break; end
         @(negedge clk);
      end
      // start presented in the DONE cycle must be dropped
      bus.xfc_div_i = 3'd5; bus.xfc_len_i = '0; bus.xfc_start_i = 1'b1;
      @(negedge clk);
      bus.xfc_start_i = 1'b0;
      n_checks++;
      if (to || bus.xfc_busy_o !== 1'b0 || bus.clkd_clk_div_o !== 3'd2) begin
         n_fail++; $display("FAIL b2b_done_start: busy=%b div=%0d to=%b want 0 2 0",
                            bus.xfc_busy_o, bus.clkd_clk_div_o, to);
      end
      n_checks++;
      if (n_done != 1 || ev != exp_seq(7, 0)) begin
         n_fail++; $display("FAIL b2b_first: done=%0d strobes=%s want 1 %s", n_done, ev, exp_seq(7, 0));
      end
      test_transfer("b2b_after", 5, 3, 0);
   endtask

   task automatic test_reset_mid();
      bit to;
      mon_reset();
      do_start(1, 7, 0);
      to = 1'b1;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clk);
         if (n_xfer_tb >= 8) begin to = 1'b0; break; end
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (to || {bus.xfc_busy_o, bus.xfc_done_o, bus.xfc_cs_n_o, bus.xfc_sck_en_o, bus.xfc_shift_o,
           bus.xfc_sample_o, bus.clkd_enable_o} !== 7'b0010000 || bus.clkd_clk_div_o !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got %b div=%0d to=%b want 0010000 0 0", {bus.xfc_busy_o,
                  bus.xfc_done_o, bus.xfc_cs_n_o, bus.xfc_sck_en_o, bus.xfc_shift_o, bus.xfc_sample_o,
                  bus.clkd_enable_o}, bus.clkd_clk_div_o, to);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (n_done != 0) begin n_fail++; $display("FAIL mid_reset_done: got %0d want 0", n_done); end
      test_transfer("post_reset", 4, 5, 1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++)
         test_transfer("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)));
   endtask

`ifdef SPI_IP_XFER_CTRL_ABORT_EN
   task automatic test_abort();
      bit to;
      mon_reset();
      do_start(1, 7, 0);
      to = 1'b1;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clk);
         if (bus.clkd_time_base_i && bus.xfc_sck_en_o && n_xfer_tb == 4) begin to = 1'b0; break; end
      end
      bus.xfc_abort_i = 1'b1;
      @(negedge clk);
      bus.xfc_abort_i = 1'b0;
      n_checks++;
      if (to || bus.xfc_done_o !== 1'b1 || bus.xfc_cs_n_o !== 1'b1 || bus.clkd_enable_o !== 1'b0 ||
          bus.xfc_aborted_o !== 1'b1) begin
         n_fail++; $display("FAIL abort_done: done=%b cs_n=%b en=%b aborted=%b to=%b want 1 1 0 1 0",
                            bus.xfc_done_o, bus.xfc_cs_n_o, bus.clkd_enable_o, bus.xfc_aborted_o, to);
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (ev != "asas" || n_done != 1 || bus.xfc_busy_o !== 1'b0) begin
         n_fail++; $display("FAIL abort_after: strobes=%s done=%0d busy=%b want asas 1 0", ev, n_done,
                            bus.xfc_busy_o);
      end
      test_transfer("post_abort", 2, 3, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_transfer("basic", 0, 7, 0);
      test_transfer("min_cpha1", 3, 0, 1);
      test_back_to_back();
      test_reset_mid();
      test_transfer("max_len", 7, 31, 0);
      test_random();
`ifdef SPI_IP_XFER_CTRL_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
